// File: rtl/dvp_camera_tx.sv
// DVP camera sensor emulator: serialises 128-bit pixel words onto vsync/href/data
// pins with programmable frame timing. All pin outputs are registered.
module dvp_camera_tx #(
  parameter int unsigned LINE_BYTES = 1280,
  parameter int unsigned H_BLANK    = 144,
  parameter int unsigned ACT_LINES  = 480,
  parameter int unsigned VS_LINES   = 4,
  parameter int unsigned VBP_LINES  = 18,
  parameter int unsigned VFP_LINES  = 10
) (
  input  logic         pclk,
  input  logic         HReset_N,
  input  logic         i_En,
  input  logic         i_VsyncInv,
  input  logic         i_HrefInv,
  input  logic [127:0] i_Data,
  input  logic         i_Valid,
  output logic         o_Ready,
  output logic         vsync,
  output logic         href,
  output logic [7:0]   data,
  output logic         o_FrameStart,
  output logic         o_Underrun,
  output logic         o_Busy
);

  localparam int unsigned LinePeriod = LINE_BYTES + H_BLANK;
  localparam int unsigned FrameLines = VS_LINES + VBP_LINES + ACT_LINES + VFP_LINES;
  localparam int unsigned HW = $clog2(LinePeriod + 1);
  localparam int unsigned VW = $clog2(FrameLines + 1);

  localparam logic [HW-1:0] HLast    = HW'(LinePeriod - 1);
  localparam logic [HW-1:0] HActEnd  = HW'(LINE_BYTES);
  localparam logic [VW-1:0] VLast    = VW'(FrameLines - 1);
  localparam logic [VW-1:0] VbpStart = VW'(VS_LINES);
  localparam logic [VW-1:0] ActStart = VW'(VS_LINES + VBP_LINES);
  localparam logic [VW-1:0] VfpStart = VW'(VS_LINES + VBP_LINES + ACT_LINES);

  typedef enum logic [2:0] {StIdle, StVsync, StVbp, StActive, StVfp} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic            vinv_q, hinv_q;
  logic            hold_v_q, hold_v_d;
  logic [127:0]    hold_data_q, hold_data_d;
  logic [127:0]    shift_q, shift_d;
  logic [127:0]    load_word;
  logic [7:0]      byte_d;
  logic            h_wrap, frame_end, frame_go;
  logic            vs_raw, hr_raw, slot_load, accept, frame_first;

  // Empty zero-length regions (VBP/VFP of 0 lines) fall through naturally.
  function automatic state_e region(logic [VW-1:0] v);
    if (v < VbpStart)      return StVsync;
    else if (v < ActStart) return StVbp;
    else if (v < VfpStart) return StActive;
    else                   return StVfp;
  endfunction

  assign h_wrap    = (h_cnt_q == HLast);
  assign frame_end = (state_q != StIdle) && h_wrap && (v_cnt_q == VLast);
  // A new frame starts (and polarities are relatched) on this edge.
  assign frame_go  = i_En && ((state_q == StIdle) || frame_end);

  // State register
  always_ff @(posedge pclk or negedge HReset_N) begin
    if (!HReset_N) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // Next-state: counters advance outside IDLE, state tracks the v_cnt region
  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (state_q != StIdle) begin
      if (h_wrap) begin
        v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
      end
    end
    state_d = state_q;
    case (state_q)
      StIdle:  state_d = i_En ? StVsync : StIdle;
      default: begin
        if (frame_end) state_d = i_En ? StVsync : StIdle;
        else           state_d = region(v_cnt_d);
      end
    endcase
  end

  // Outputs decoded from state and counters
  always_comb begin
    vs_raw      = (state_q == StVsync);
    hr_raw      = (state_q == StActive) && (h_cnt_q < HActEnd);
    slot_load   = hr_raw && (h_cnt_q[3:0] == 4'd0);
    o_Ready     = ~hold_v_q | slot_load;
    accept      = i_Valid & o_Ready;
    o_Underrun  = slot_load & ~hold_v_q;
    o_Busy      = (state_q != StIdle);
    frame_first = vs_raw && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Counters and latched pin polarities
  always_ff @(posedge pclk or negedge HReset_N) begin
    if (!HReset_N) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      vinv_q  <= 1'b0;
      hinv_q  <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      if (frame_go) begin
        vinv_q <= i_VsyncInv;
        hinv_q <= i_HrefInv;
      end
    end
  end

  // Hold register refill and LSB-first byte shifter; an empty hold yields a zero slot
  always_comb begin
    load_word   = hold_v_q ? hold_data_q : '0;
    hold_data_d = accept ? i_Data : hold_data_q;
    hold_v_d    = hold_v_q;
    if (slot_load)   hold_v_d = accept;
    else if (accept) hold_v_d = 1'b1;
    shift_d = shift_q;
    byte_d  = 8'h00;
    if (slot_load) begin
      shift_d = load_word >> 8;
      byte_d  = load_word[7:0];
    end else if (hr_raw) begin
      shift_d = shift_q >> 8;
      byte_d  = shift_q[7:0];
    end
  end

  // Datapath state
  always_ff @(posedge pclk or negedge HReset_N) begin
    if (!HReset_N) begin
      hold_v_q    <= 1'b0;
      hold_data_q <= '0;
      shift_q     <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_data_q <= hold_data_d;
      shift_q     <= shift_d;
    end
  end

  // Registered pins, one cycle behind the counters
  always_ff @(posedge pclk or negedge HReset_N) begin
    if (!HReset_N) begin
      vsync        <= 1'b0;
      href         <= 1'b0;
      data         <= 8'h00;
      o_FrameStart <= 1'b0;
    end else begin
      vsync        <= vs_raw ^ vinv_q;
      href         <= hr_raw ^ hinv_q;
      data         <= byte_d;
      o_FrameStart <= frame_first;
    end
  end

endmodule

// File: tb/tb_dvp_camera_tx.sv
// Bench for dvp_camera_tx: random pixel words, frame-level pin model.
module tb_dvp_camera_tx;

  localparam int LB = 32, HB = 8, AL = 2, VSL = 1, VBPL = 1, VFPL = 1;
  localparam int LinePer  = LB + HB;
  localparam int FramePer = LinePer * (VSL + VBPL + AL + VFPL);
  localparam int ActK     = LinePer * (VSL + VBPL);

  logic         pclk = 1'b0;
  logic         rst_n, i_En, vinv_in, hinv_in, i_Valid;
  logic [127:0] i_Data;
  logic         o_Ready, vsync, href, o_FrameStart, o_Underrun, o_Busy;
  logic [7:0]   data;

  int           n_checks = 0;
  int           n_fail = 0;
  int           acc_cnt = 0;
  logic [127:0] src_q[$];
  logic [127:0] acc_q[$];

  dvp_camera_tx #(
    .LINE_BYTES(LB), .H_BLANK(HB), .ACT_LINES(AL),
    .VS_LINES(VSL), .VBP_LINES(VBPL), .VFP_LINES(VFPL)
  ) dut (
    .pclk(pclk), .HReset_N(rst_n), .i_En(i_En), .i_VsyncInv(vinv_in),
    .i_HrefInv(hinv_in), .i_Data(i_Data), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .vsync(vsync), .href(href), .data(data), .o_FrameStart(o_FrameStart),
    .o_Underrun(o_Underrun), .o_Busy(o_Busy)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Word source: presents the queue head; a handshake moves it to the accepted queue
  always @(negedge pclk) begin
    if (rst_n && src_q.size() > 0) begin
      i_Valid = 1'b1;
      i_Data  = src_q[0];
    end else begin
      i_Valid = 1'b0;
    end
    if (i_Valid && o_Ready) begin
      acc_q.push_back(src_q.pop_front());
      acc_cnt++;
    end
  end

  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  // Checks one frame, k = pin cycles since vsync assertion. Bytes come from accepted
  // words in order; under_slot (0..3) is the slot expected to find no word.
  task automatic run_frame(input logic vinv, input logic hinv, input int under_slot,
                           input int refill_k, input int pol_k, input logic new_v,
                           input logic new_h, input int drop_k, input int stop_k);
    logic [127:0] cur;
    logic [7:0]   exp_byte;
    logic         in_act;
    int           acc0, under_k, off, line;
    under_k = (under_slot < 0) ? -1 :
              ActK + (under_slot / 2) * LinePer + (under_slot % 2) * 16 - 1;
    acc0 = acc_cnt;
    cur  = '0;
    for (int k = 0; k < stop_k; k++) begin
      in_act = (k >= ActK) && (k < ActK + AL * LinePer) && (((k - ActK) % LinePer) < LB);
      exp_byte = 8'h00;
      if (in_act) begin
        off  = (k - ActK) % LinePer;
        line = (k - ActK) / LinePer;
        if (off % 16 == 0) begin
          if (line * 2 + off / 16 == under_slot) begin
            cur = '0;
          end else begin
            check_eq("word_avail", acc_q.size() > 0, 1'b1);
            cur = (acc_q.size() > 0) ? acc_q.pop_front() : '0;
          end
        end
        exp_byte = cur[8*(off%16) +: 8];
      end
      check_eq("vsync", vsync, (k < LinePer * VSL) ^ vinv);
      check_eq("href", href, in_act ^ hinv);
      check_eq("data", data, exp_byte);
      check_eq("frame_start", o_FrameStart, k == 0);
      check_eq("underrun", o_Underrun, k == under_k);
      check_eq("busy", o_Busy, !(k == FramePer - 1 && drop_k >= 0));
      if (k == refill_k) for (int i = 0; i < 8; i++) src_q.push_back(rand_word());
      if (k == pol_k) begin
        vinv_in = new_v;
        hinv_in = new_h;
      end
      if (k == drop_k) i_En = 1'b0;
      step();
    end
    if (stop_k == FramePer) check_eq("words_per_frame", acc_cnt - acc0, under_slot < 0 ? 4 : 3);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    i_En = 1'b0;
    vinv_in = 1'b0;
    hinv_in = 1'b0;
    step();
    step();
    src_q.delete();
    acc_q.delete();
  endtask

  task automatic start_frames();
    i_En = 1'b1;
    step();
    step();
  endtask

  initial begin
    logic [127:0] w;
    rst_n = 1'b1;
    i_En = 1'b0;
    vinv_in = 1'b0;
    hinv_in = 1'b0;
    i_Valid = 1'b0;
    i_Data = '0;
    #1 reset_dut();
    check_eq("rst_vsync", vsync, 1'b0);
    check_eq("rst_href", href, 1'b0);
    check_eq("rst_data", data, 8'h00);
    check_eq("rst_ready", o_Ready, 1'b1);
    check_eq("rst_fs", o_FrameStart, 1'b0);
    check_eq("rst_underrun", o_Underrun, 1'b0);
    check_eq("rst_busy", o_Busy, 1'b0);

    // Known byte ramp then random words; polarity change mid-frame, enable drop in frame 2
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 16; i++) w[8*i +: 8] = 8'(16 * j + i);
      src_q.push_back(w);
    end
    for (int i = 0; i < 10; i++) src_q.push_back(rand_word());
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check_eq("idle_prefetch_ready", o_Ready, 1'b0);
    check_eq("idle_vsync", vsync, 1'b0);
    check_eq("idle_busy", o_Busy, 1'b0);
    start_frames();
    run_frame(1'b0, 1'b0, -1, -1, 100, 1'b1, 1'b1, -1, FramePer);
    run_frame(1'b1, 1'b1, -1, -1, 100, 1'b0, 1'b0, 100, FramePer);
    for (int i = 0; i < 50; i++) begin
      check_eq("post_vsync", vsync, 1'b1);
      check_eq("post_href", href, 1'b1);
      check_eq("post_data", data, 8'h00);
      check_eq("post_fs", o_FrameStart, 1'b0);
      check_eq("post_busy", o_Busy, 1'b0);
      check_eq("post_ready", o_Ready, 1'b0);
      step();
    end

    // Underrun on line 0 slot 1, then reset in the middle of the next frame's line
    reset_dut();
    src_q.push_back(rand_word());
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    start_frames();
    run_frame(1'b0, 1'b0, 1, 96, -1, 1'b0, 1'b0, -1, FramePer);
    run_frame(1'b0, 1'b0, -1, -1, -1, 1'b0, 1'b0, -1, 90);
    check_eq("pre_rst_href", href, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_vsync", vsync, 1'b0);
    check_eq("midrst_href", href, 1'b0);
    check_eq("midrst_data", data, 8'h00);
    check_eq("midrst_ready", o_Ready, 1'b1);
    check_eq("midrst_busy", o_Busy, 1'b0);
    check_eq("midrst_underrun", o_Underrun, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
